// File: rtl/clock_pkg.sv
// clock_pkg: shared limits, bus width and display type for the digital-clock counter chain.
package clock_pkg;
  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;
  localparam int HOUR_MAX = 23;
  localparam int TIME_W = 8;
  typedef logic [TIME_W-1:0] time_t;
endpackage

// File: rtl/min_bcd_conv.sv
// min_bcd_conv: binary->packed-BCD display path and BCD preset decode/validity (used under COUNTER_MIN_BCD_EN).
module min_bcd_conv #(
  parameter int MIN_MAX = 59,
  parameter int W = 8
) (
  input  logic [5:0]   cnt_i,
  input  logic [W-1:0] pre_i,
  output logic [W-1:0] show_o,
  output logic [5:0]   pre_bin_o,
  output logic         pre_ok_o
);
  logic [6:0] val;
  assign show_o = W'({4'(cnt_i / 6'd10), 4'(cnt_i % 6'd10)});
  assign val = 7'(pre_i[7:4]) * 7'd10 + 7'(pre_i[3:0]);
  assign pre_bin_o = val[5:0];
  // Bits above the two BCD digits must be clear for the preset to be a valid minute.
  assign pre_ok_o = pre_i[7:4] <= 4'd9 && pre_i[3:0] <= 4'd9 && val <= 7'(MIN_MAX) && (pre_i >> 8) == '0;
endmodule

// File: rtl/counter_min.sv
// counter_min: minutes stage 0..MIN_MAX clocked by the seconds carry, with preset and wrap carry.
// Define COUNTER_MIN_BCD_EN for packed-BCD pre_min/show_min; plain binary otherwise.
module counter_min #(
  parameter int MIN_MAX = clock_pkg::MIN_MAX,
  parameter int W = clock_pkg::TIME_W
) (
  input  logic         cin_sec,
  input  logic         CR,
  input  logic         PE,
  input  logic [W-1:0] pre_min,
  output logic [W-1:0] show_min,
  output logic         cin_min
);
  import clock_pkg::*;
  logic [5:0] cnt_q, cnt_d, pre_bin;
  logic cin_q, cin_d, pre_ok;
`ifdef COUNTER_MIN_BCD_EN
  min_bcd_conv #(.MIN_MAX(MIN_MAX), .W(W)) u_conv (
    .cnt_i(cnt_q),
    .pre_i(pre_min),
    .show_o(show_min),
    .pre_bin_o(pre_bin),
    .pre_ok_o(pre_ok)
  );
`else
  assign show_min = W'(cnt_q);
  assign pre_bin = pre_min[5:0];
  assign pre_ok = pre_min <= W'(MIN_MAX);
`endif
  // A preset on the wrap edge wins and swallows the carry.
  always_comb begin
    cnt_d = PE ? (pre_ok ? pre_bin : '0) : (cnt_q == 6'(MIN_MAX) ? '0 : cnt_q + 6'd1);
    cin_d = !PE && cnt_q == 6'(MIN_MAX);
  end
  always_ff @(posedge cin_sec or posedge CR)
    if (CR) begin
      cnt_q <= '0;
      cin_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      cin_q <= cin_d;
    end
  assign cin_min = cin_q;
endmodule

// File: tb/tb_counter_min.sv
// tb_counter_min: directed + random stimulus against an arithmetic minute-counter model.
module tb_counter_min;
  logic cin_sec = 1'b0;
  logic CR, PE;
  logic [7:0] pre_min, show_min;
  logic cin_min;
  int checks = 0, errors = 0;
  int m_cnt = 0;
  logic m_cin = 1'b0;

  counter_min dut (
    .cin_sec(cin_sec),
    .CR(CR),
    .PE(PE),
    .pre_min(pre_min),
    .show_min(show_min),
    .cin_min(cin_min)
  );

  always #5 cin_sec = ~cin_sec;

  function automatic logic [7:0] enc(int n);
`ifdef COUNTER_MIN_BCD_EN
    return 8'(((n / 10) << 4) | (n % 10));
`else
    return 8'(n);
`endif
  endfunction

  function automatic int decode(logic [7:0] p);
    int v;
`ifdef COUNTER_MIN_BCD_EN
    if (p[7:4] > 9 || p[3:0] > 9) return 0;
    v = int'(p[7:4]) * 10 + int'(p[3:0]);
`else
    v = int'(p);
`endif
    return (v <= 59) ? v : 0;
  endfunction

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(string tag);
    chk({tag, "_show"}, show_min, enc(m_cnt));
    chk({tag, "_cin"}, {7'd0, cin_min}, {7'd0, m_cin});
  endtask

  task automatic tick(logic pe, logic [7:0] pre, string tag);
    PE = pe;
    pre_min = pre;
    @(posedge cin_sec);
    if (pe) begin
      m_cnt = decode(pre);
      m_cin = 1'b0;
    end else begin
      m_cin = (m_cnt == 59);
      m_cnt = (m_cnt + 1) % 60;
    end
    #1;
    check_model(tag);
  endtask

  initial begin
    CR = 1'b0;
    PE = 1'b0;
    pre_min = 8'h00;
    #1 CR = 1'b1;
    PE = 1'bx;
    pre_min = 8'hxx;
    #2;
    for (int i = 0; i < 3; i++) begin
      chk("reset_show", show_min, 8'h00);
      chk("reset_cin", {7'd0, cin_min}, 8'h00);
      #5;
    end
    #1 CR = 1'b0;
    PE = 1'b0;
    #1 check_model("release");
    tick(1'b1, enc(55), "preset55");
    for (int i = 0; i < 7; i++) tick(1'b0, 8'h00, "count");
`ifdef COUNTER_MIN_BCD_EN
    tick(1'b1, 8'h5A, "invalid_nibble");
    tick(1'b1, 8'h75, "invalid_range");
`else
    tick(1'b1, 8'd75, "invalid_range");
    tick(1'b1, 8'd60, "invalid_60");
`endif
    tick(1'b1, enc(59), "preset59");
    tick(1'b1, enc(10), "collision");
    for (int i = 0; i < 3; i++) tick(1'b1, enc(30), "pe_held");
    tick(1'b1, enc(0), "preset0");
    tick(1'b1, enc(59), "preset59b");
    tick(1'b0, 8'h00, "wrap");
    #2 CR = 1'b1;
    m_cnt = 0;
    m_cin = 1'b0;
    #1 check_model("async_mid_carry");
    #1 CR = 1'b0;
    tick(1'b0, 8'h00, "after_reset");
    for (int i = 0; i < 400; i++) begin
      logic pe;
      logic [7:0] pre;
      pe = ($urandom_range(0, 9) == 0);
      pre = ($urandom_range(0, 1) == 0) ? enc(int'($urandom_range(0, 59))) : 8'($urandom_range(0, 255));
      tick(pe, pre, "random");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
